// File: rtl/aes_sbox_arbiter.sv
// Arbitrates one shared combinational AES S-box between the round datapath
// (128-bit SubBytes) and key expansion (32-bit SubWord); one request in flight.
module aes_sbox_arbiter #(
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [127:0]     st_data,
    output logic             st_resp_valid,
    input  logic             st_resp_ready,
    output logic [127:0]     st_resp_data,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [31:0]      key_data,
    output logic             key_resp_valid,
    input  logic             key_resp_ready,
    output logic [31:0]      key_resp_data,
    output logic [127:0]     sbox_in,
    output logic [31:0]      sbox_key_in,
    output logic             sbox_key_gen,
    input  logic [127:0]     sbox_out,
    input  logic [31:0]      sbox_key_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_st,
    output logic [CNT_W-1:0] cnt_key
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_ST  = 1'b0;
    localparam logic OWN_KEY = 1'b1;
    localparam logic FIXED   = (FIXED_PRIO != 0);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [127:0]     op_q, op_d;
    logic [127:0]     res_q, res_d;
    logic [CNT_W-1:0] cnt_st_q, cnt_st_d;
    logic [CNT_W-1:0] cnt_key_q, cnt_key_d;

    logic idle, eval, resp;
    logic st_hs, key_hs;
    logic own_key;

    always_comb begin
        idle    = (state_q == S_IDLE);
        eval    = (state_q == S_EVAL);
        resp    = (state_q == S_RESP);
        own_key = (owner_q == OWN_KEY);

        // Each ready depends only on the other side's valid, so the two
        // handshakes can never complete in the same cycle.
        st_ready  = idle & (!key_valid | (!FIXED & (last_grant_q == OWN_KEY)));
        key_ready = idle & (!st_valid | FIXED | (last_grant_q == OWN_ST));
        st_hs     = st_valid & st_ready;
        key_hs    = key_valid & key_ready;

        sbox_in      = (eval & !own_key) ? op_q : '0;
        sbox_key_in  = (eval & own_key) ? op_q[31:0] : '0;
        sbox_key_gen = eval & own_key;

        st_resp_valid  = resp & !own_key;
        key_resp_valid = resp & own_key;
        st_resp_data   = res_q;
        key_resp_data  = res_q[31:0];

        cnt_st  = cnt_st_q;
        cnt_key = cnt_key_q;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        res_d        = res_q;

        case (state_q)
            S_IDLE: begin
                if (st_hs) begin
                    op_d         = st_data;
                    owner_d      = OWN_ST;
                    last_grant_d = OWN_ST;
                    state_d      = S_EVAL;
                end else if (key_hs) begin
                    op_d         = {96'd0, key_data};
                    owner_d      = OWN_KEY;
                    last_grant_d = OWN_KEY;
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: begin
                res_d   = own_key ? {96'd0, sbox_key_out} : sbox_out;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (own_key ? key_resp_ready : st_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clear beats a same-cycle handshake; counts stick at all-ones.
    always_comb begin
        cnt_st_d  = cnt_st_q;
        cnt_key_d = cnt_key_q;
        if (cnt_clr) begin
            cnt_st_d  = '0;
            cnt_key_d = '0;
        end else begin
            if (st_hs && (cnt_st_q != '1)) begin
                cnt_st_d = cnt_st_q + CNT_ONE;
            end
            if (key_hs && (cnt_key_q != '1)) begin
                cnt_key_d = cnt_key_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_ST;
            last_grant_q <= OWN_KEY;
            op_q         <= '0;
            res_q        <= '0;
            cnt_st_q     <= '0;
            cnt_key_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            res_q        <= res_d;
            cnt_st_q     <= cnt_st_d;
            cnt_key_q    <= cnt_key_d;
        end
    end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter with a FIPS-197 S-box model and a
// response scoreboard; extra instances cover fixed priority and CNT_W=2.
module tb_aes_sbox_arbiter;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_HEX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [127:0] sbox128(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(x[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] sbox32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(x[8*i +: 8]);
        return r;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         st_valid, st_ready, st_resp_valid, st_resp_ready;
    logic [127:0] st_data, st_resp_data;
    logic         key_valid, key_ready, key_resp_valid, key_resp_ready;
    logic [31:0]  key_data, key_resp_data;
    logic [127:0] sbox_in, sbox_out;
    logic [31:0]  sbox_key_in, sbox_key_out;
    logic         sbox_key_gen, cnt_clr;
    logic [15:0]  cnt_st, cnt_key;

    logic         c2_st_ready, c2_st_resp_valid, c2_key_ready, c2_key_resp_valid;
    logic [127:0] c2_st_resp_data, c2_sbox_in, c2_sbox_out;
    logic [31:0]  c2_key_resp_data, c2_sbox_key_in, c2_sbox_key_out;
    logic         c2_sbox_key_gen;
    logic [1:0]   c2_cnt_st, c2_cnt_key;

    logic         f_st_valid, f_st_ready, f_st_resp_valid, f_resp_ready;
    logic [127:0] f_st_data, f_st_resp_data, f_sbox_in, f_sbox_out;
    logic         f_key_valid, f_key_ready, f_key_resp_valid, f_sbox_key_gen;
    logic [31:0]  f_key_data, f_key_resp_data, f_sbox_key_in, f_sbox_key_out;
    logic [15:0]  f_cnt_st, f_cnt_key;

    always_comb begin
        sbox_out        = sbox128(sbox_in);
        sbox_key_out    = sbox32(sbox_key_in);
        c2_sbox_out     = sbox128(c2_sbox_in);
        c2_sbox_key_out = sbox32(c2_sbox_key_in);
        f_sbox_out      = sbox128(f_sbox_in);
        f_sbox_key_out  = sbox32(f_sbox_key_in);
    end

    aes_sbox_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .st_resp_valid(st_resp_valid), .st_resp_ready(st_resp_ready),
        .st_resp_data(st_resp_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .key_resp_valid(key_resp_valid), .key_resp_ready(key_resp_ready),
        .key_resp_data(key_resp_data),
        .sbox_in(sbox_in), .sbox_key_in(sbox_key_in), .sbox_key_gen(sbox_key_gen),
        .sbox_out(sbox_out), .sbox_key_out(sbox_key_out),
        .cnt_clr(cnt_clr), .cnt_st(cnt_st), .cnt_key(cnt_key)
    );

    aes_sbox_arbiter #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(c2_st_ready), .st_data(st_data),
        .st_resp_valid(c2_st_resp_valid), .st_resp_ready(st_resp_ready),
        .st_resp_data(c2_st_resp_data),
        .key_valid(key_valid), .key_ready(c2_key_ready), .key_data(key_data),
        .key_resp_valid(c2_key_resp_valid), .key_resp_ready(key_resp_ready),
        .key_resp_data(c2_key_resp_data),
        .sbox_in(c2_sbox_in), .sbox_key_in(c2_sbox_key_in),
        .sbox_key_gen(c2_sbox_key_gen),
        .sbox_out(c2_sbox_out), .sbox_key_out(c2_sbox_key_out),
        .cnt_clr(cnt_clr), .cnt_st(c2_cnt_st), .cnt_key(c2_cnt_key)
    );

    aes_sbox_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .st_valid(f_st_valid), .st_ready(f_st_ready), .st_data(f_st_data),
        .st_resp_valid(f_st_resp_valid), .st_resp_ready(f_resp_ready),
        .st_resp_data(f_st_resp_data),
        .key_valid(f_key_valid), .key_ready(f_key_ready), .key_data(f_key_data),
        .key_resp_valid(f_key_resp_valid), .key_resp_ready(f_resp_ready),
        .key_resp_data(f_key_resp_data),
        .sbox_in(f_sbox_in), .sbox_key_in(f_sbox_key_in),
        .sbox_key_gen(f_sbox_key_gen),
        .sbox_out(f_sbox_out), .sbox_key_out(f_sbox_key_out),
        .cnt_clr(1'b0), .cnt_st(f_cnt_st), .cnt_key(f_cnt_key)
    );

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_st[$];
    logic [31:0]  exp_key[$];
    logic         grants[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (st_valid && st_ready) begin
                exp_st.push_back(sbox128(st_data));
                grants.push_back(1'b0);
            end
            if (key_valid && key_ready) begin
                exp_key.push_back(sbox32(key_data));
                grants.push_back(1'b1);
            end
            if (st_resp_valid && st_resp_ready) begin
                if (exp_st.size() == 0) chk("st_resp_unexpected", 128'(st_resp_valid), 128'd0);
                else chk("st_resp_data", st_resp_data, exp_st.pop_front());
            end
            if (key_resp_valid && key_resp_ready) begin
                if (exp_key.size() == 0) chk("key_resp_unexpected", 128'(key_resp_valid), 128'd0);
                else chk("key_resp_data", 128'(key_resp_data), 128'(exp_key.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_st(input logic [127:0] d);
        int c = 0;
        st_valid = 1'b1;
        st_data  = d;
        @(negedge clk);
        while (!st_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (c >= 20) timeout("st_handshake");
        tick();
        st_valid = 1'b0;
    endtask

    task automatic issue_key(input logic [31:0] d);
        int c = 0;
        key_valid = 1'b1;
        key_data  = d;
        @(negedge clk);
        while (!key_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (c >= 20) timeout("key_handshake");
        tick();
        key_valid = 1'b0;
    endtask

    task automatic drain;
        int c = 0;
        @(negedge clk);
        while ((exp_st.size() != 0 || exp_key.size() != 0) && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (c >= 20) timeout("drain");
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nk, c;
        logic s, k;
        logic [127:0] held;
        logic fg[$];

        rst_n = 1'b0;
        st_valid = 1'b0; st_data = '0; st_resp_ready = 1'b1;
        key_valid = 1'b0; key_data = '0; key_resp_ready = 1'b1;
        cnt_clr = 1'b0;
        f_st_valid = 1'b0; f_st_data = '0; f_key_valid = 1'b0;
        f_key_data = '0; f_resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", 128'(st_ready), 128'd1);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_st_resp_valid", 128'(st_resp_valid), 128'd0);
        chk("rst_key_resp_valid", 128'(key_resp_valid), 128'd0);
        chk("rst_cnt_st", 128'(cnt_st), 128'd0);
        chk("rst_cnt_key", 128'(cnt_key), 128'd0);
        chk("rst_sbox_in", sbox_in, 128'd0);
        chk("rst_key_gen", 128'(sbox_key_gen), 128'd0);
        tick();
        rst_n = 1'b1;

        // Single ST request, latency 2
        st_valid = 1'b1;
        st_data  = 128'h000102030405060708090a0b0c0d0e0f;
        @(negedge clk);
        chk("a_st_ready", 128'(st_ready), 128'd1);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("a_eval_sbox_in", sbox_in, 128'h000102030405060708090a0b0c0d0e0f);
        chk("a_eval_key_gen", 128'(sbox_key_gen), 128'd0);
        chk("a_eval_readies", 128'({st_ready, key_ready}), 128'd0);
        chk("a_eval_resp_valid", 128'(st_resp_valid), 128'd0);
        tick();
        @(negedge clk);
        chk("a_resp_valid", 128'(st_resp_valid), 128'd1);
        chk("a_resp_data", st_resp_data, 128'h637c777bf26b6fc53001672bfed7ab76);
        chk("a_cnt_st", 128'(cnt_st), 128'd1);
        tick();

        // Single KEY request
        key_valid = 1'b1;
        key_data  = 32'hcf4f3c09;
        @(negedge clk);
        chk("b_idle_key_gen", 128'(sbox_key_gen), 128'd0);
        tick();
        key_valid = 1'b0;
        @(negedge clk);
        chk("b_eval_key_in", 128'(sbox_key_in), 128'(32'hcf4f3c09));
        chk("b_eval_key_gen", 128'(sbox_key_gen), 128'd1);
        chk("b_eval_sbox_in", sbox_in, 128'd0);
        tick();
        @(negedge clk);
        chk("b_resp_valid", 128'(key_resp_valid), 128'd1);
        chk("b_resp_data", 128'(key_resp_data), 128'(32'h8a84eb01));
        chk("b_resp_key_gen", 128'(sbox_key_gen), 128'd0);
        chk("b_cnt_key", 128'(cnt_key), 128'd1);
        tick();

        // Round-robin under contention
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("c_clr_cnt_st", 128'(cnt_st), 128'd0);
        chk("c_clr_cnt_key", 128'(cnt_key), 128'd0);
        tick();
        grants.delete();
        ns = 0; nk = 0;
        st_valid = 1'b1; st_data = {4{$urandom}};
        key_valid = 1'b1; key_data = $urandom;
        for (int i = 0; i < 60 && (ns + nk) < 6; i++) begin
            @(negedge clk);
            s = st_valid && st_ready;
            k = key_valid && key_ready;
            tick();
            if (s) begin
                ns++;
                st_data = {4{$urandom}};
                if (ns == 3) st_valid = 1'b0;
            end
            if (k) begin
                nk++;
                key_data = $urandom;
                if (nk == 3) key_valid = 1'b0;
            end
        end
        if ((ns + nk) < 6) timeout("c_grants");
        st_valid = 1'b0; key_valid = 1'b0;
        drain();
        chk("c_grant_count", 128'(grants.size()), 128'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("c_grant%0d", i), 128'(grants[i]), 128'(i % 2));
        chk("c_cnt_st", 128'(cnt_st), 128'd3);
        chk("c_cnt_key", 128'(cnt_key), 128'd3);

        // Response back-pressure
        st_resp_ready = 1'b0;
        grants.delete();
        issue_st(128'h00112233445566778899aabbccddeeff);
        key_valid = 1'b1;
        key_data  = 32'h01020304;
        tick();
        @(negedge clk);
        chk("d_resp_valid", 128'(st_resp_valid), 128'd1);
        held = st_resp_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("d_hold_data", st_resp_data, sbox128(128'h00112233445566778899aabbccddeeff));
            chk("d_hold_stable", st_resp_data, held);
            chk("d_hold_readies", 128'({st_ready, key_ready}), 128'd0);
        end
        chk("d_no_grant", 128'(grants.size()), 128'd1);
        tick();
        st_resp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("d_key_ready_after", 128'(key_ready), 128'd1);
        tick();
        key_valid = 1'b0;
        drain();

        // Reset during EVAL
        st_valid = 1'b1;
        st_data  = {4{32'hdeadbeef}};
        @(negedge clk);
        tick();
        st_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_eval_sbox_in", sbox_in, {4{32'hdeadbeef}});
        tick();
        rst_n = 1'b1;
        exp_st.delete();
        exp_key.delete();
        @(negedge clk);
        chk("e_st_resp_valid", 128'(st_resp_valid), 128'd0);
        chk("e_key_resp_valid", 128'(key_resp_valid), 128'd0);
        chk("e_cnt_st", 128'(cnt_st), 128'd0);
        chk("e_cnt_key", 128'(cnt_key), 128'd0);
        chk("e_idle_ready", 128'(st_ready), 128'd1);
        chk("e_idle_sbox_in", sbox_in, 128'd0);
        tick();

        // Saturation at CNT_W=2 and clear-wins
        for (int i = 0; i < 5; i++) begin
            issue_st({4{$urandom}});
            drain();
        end
        chk("f_c2_saturate", 128'(c2_cnt_st), 128'd3);
        chk("f_cnt_st5", 128'(cnt_st), 128'd5);
        st_valid = 1'b1;
        st_data  = 128'h1;
        cnt_clr  = 1'b1;
        @(negedge clk);
        chk("f_clr_hs_ready", 128'(st_ready), 128'd1);
        tick();
        st_valid = 1'b0;
        cnt_clr  = 1'b0;
        @(negedge clk);
        chk("f_clr_cnt_st", 128'(cnt_st), 128'd0);
        chk("f_clr_c2_cnt_st", 128'(c2_cnt_st), 128'd0);
        drain();

        // Fixed priority: key wins every tie
        f_st_valid  = 1'b1; f_st_data = 128'h5;
        f_key_valid = 1'b1; f_key_data = 32'h7;
        ns = 0; nk = 0;
        for (c = 0; c < 40 && (ns + nk) < 3; c++) begin
            @(negedge clk);
            s = f_st_valid && f_st_ready;
            k = f_key_valid && f_key_ready;
            if (s) fg.push_back(1'b0);
            if (k) fg.push_back(1'b1);
            tick();
            if (k) begin
                nk++;
                if (nk == 2) f_key_valid = 1'b0;
            end
            if (s) begin
                ns++;
                f_st_valid = 1'b0;
            end
        end
        if ((ns + nk) < 3) timeout("g_grants");
        f_st_valid = 1'b0; f_key_valid = 1'b0;
        chk("g_grant_count", 128'(fg.size()), 128'd3);
        if (fg.size() == 3) begin
            chk("g_grant0", 128'(fg[0]), 128'd1);
            chk("g_grant1", 128'(fg[1]), 128'd1);
            chk("g_grant2", 128'(fg[2]), 128'd0);
        end
        repeat (3) tick();
        chk("g_cnt_key", 128'(f_cnt_key), 128'd2);
        chk("g_cnt_st", 128'(f_cnt_st), 128'd1);

        // Exhaustive byte sweep in every lane
        for (int b = 0; b < 256; b++) begin
            issue_st({16{8'(b)}});
            drain();
        end
        for (int b = 0; b < 256; b++) begin
            issue_key({4{8'(b)}});
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
